jx2_mem_tile_resp: RTL and testbench
====================================

Name: jx2_mem_tile_resp

Overview:
- Memory-side responder for the 128-bit instruction tile-read interface driven by the fetch tile cache (memPcAddr/memPcOpm in, memPcData/memPcOK out).
- Services UMEM_OPM_RD_TILE requests by issuing four 32-bit beats to a narrow backing memory port and assembling them into one tile.
- Drives the HOLD/OK/FAULT handshake back to the requester.
- Sits between the fetch tile cache and the L2/backing RAM arbiter.

Parameters:
- ADDR_LIMIT, 48'h0000_0100_0000, first byte address not backed; any tile touching addresses >= ADDR_LIMIT faults.
- BEAT_TIMEOUT, 255, maximum cycles to wait for one backing beat before faulting (8-bit counter).

Ports:
- clock  in  1  core clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- memPcAddr  in  48  tile byte address; bits [2:0] are zero, so the tile spans addr..addr+15.
- memPcOpm  in  5  UMEM_OPM_RD_TILE = request; UMEM_OPM_READY = idle; other codes are ignored and treated as READY.
- memPcData  out  128  assembled tile, little-endian (beat0 = [31:0]).
- memPcOK  out  2  UMEM_OK_READY 2'b00, OK 2'b01, HOLD 2'b10, FAULT 2'b11.
- bkAddr  out  48  backing word address (byte address, 4-aligned).
- bkReq  out  1  backing read request; held with a stable bkAddr until bkOK.
- bkData  in  32  backing read data, valid when bkOK.
- bkOK  in  1  beat-complete strobe; ignored unless bkReq is high.

Behaviour:
- Reset: state IDLE, memPcOK=READY, memPcData=0, bkReq=0, bkAddr=0, beat index=0, timeout counter=0. Reset mid-fetch discards all partial data and drops bkReq on the next edge.
- All outputs are registered.
- State IDLE, memPcOK=READY:
  - opm==RD_TILE: latch reqAddr=memPcAddr, beat index=0.
  - If reqAddr+15 >= ADDR_LIMIT, go to FAULT; else go to FETCH.
  - On the FETCH path, bkReq=1 and bkAddr=reqAddr on the next cycle.
  - The response (HOLD) is visible 1 cycle after the request.
- State FETCH, memPcOK=HOLD:
  - On bkReq & bkOK: store bkData into tile slice [32*i+31:32*i], increment i, set bkAddr=reqAddr+4*(i+1), clear the timeout counter.
  - After beat 3, drop bkReq and go to DONE.
  - Otherwise the timeout counter increments each cycle; reaching BEAT_TIMEOUT goes to FAULT with bkReq=0.
  - Requester abort: opm!=RD_TILE or memPcAddr!=reqAddr during FETCH drops bkReq next cycle and returns to IDLE; partial data is discarded. A bkOK in the same cycle as the abort is ignored.
- Minimum latency: request at cycle 0 gives OK at cycle 6 when bkOK arrives every cycle starting at cycle 1.
- State DONE, memPcOK=OK:
  - memPcData holds the full tile, stable while in DONE.
  - opm!=RD_TILE: go to IDLE; memPcOK=READY next cycle, memPcData retained.
  - opm==RD_TILE with memPcAddr==reqAddr: stay in DONE, OK held. This covers the requester's one-cycle registered drop.
  - opm==RD_TILE with memPcAddr!=reqAddr: new request, treated exactly as from IDLE (memPcOK=HOLD next cycle).
- State FAULT, memPcOK=FAULT, memPcData=0: same exit rules as DONE.
- Address arithmetic is 48-bit unsigned. reqAddr+15 must not wrap; a wrap counts as a fault.
- Low address bits: if memPcAddr[2:0]!=0 it is still accepted; bkAddr uses {reqAddr[47:2],2'b00}+4*i.
- bkReq never asserts outside FETCH.
- At most one outstanding request is serviced; no queuing.

Test Plan:
- Basic read:
  - Stimulus: addr=48'h1000, RD_TILE; bkOK every cycle; bkData = 32'h11111111, 22222222, 33333333, 44444444.
  - Required: bkAddr sequence 1000/1004/1008/100C; memPcOK HOLD then OK at cycle 6; memPcData=128'h44444444_33333333_22222222_11111111.
  - After opm drops to READY: memPcOK=READY next cycle.
- Stalled backing:
  - Stimulus: bkOK pulses with 3 idle cycles between beats, addr=48'h2008.
  - Required: bkAddr stable during each stall; HOLD throughout; OK with correct data; bkAddr sequence 2008/200C/2010/2014.
- Out-of-range:
  - Stimulus: addr=ADDR_LIMIT-8.
  - Required: FAULT (2'b11) next cycle; bkReq never asserted; memPcData=0; READY after opm drops.
- Timeout:
  - Stimulus: addr=48'h3000, bkOK held low.
  - Required: bkReq high for 255 cycles, then memPcOK=FAULT and bkReq=0.
- Abort and re-request:
  - Stimulus: opm drops after beat 1, then RD_TILE at addr=48'h4000.
  - Required: IDLE with bkReq=0, then a fresh fetch with bkAddr restarting at 4000; final data contains no beats from the aborted request.
- Back-to-back and reset:
  - In DONE, change addr to 48'h5000 with RD_TILE held: required HOLD next cycle and a new fetch.
  - Assert reset mid-FETCH: required memPcOK=READY, bkReq=0, memPcData=0 next cycle.

Source files
------------

// File: rtl/jx2_mem_tile_resp.sv
// Memory-side responder for 128-bit instruction tile reads: fetches four 32-bit
// beats from a narrow backing port and returns them as one tile with HOLD/OK/FAULT.
module jx2_mem_tile_resp #(
  parameter logic [47:0] ADDR_LIMIT   = 48'h0000_0100_0000,
  parameter int unsigned BEAT_TIMEOUT = 255
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [47:0]  memPcAddr,
  input  logic [4:0]   memPcOpm,
  output logic [127:0] memPcData,
  output logic [1:0]   memPcOK,
  output logic [47:0]  bkAddr,
  output logic         bkReq,
  input  logic [31:0]  bkData,
  input  logic         bkOK
);

  localparam logic [4:0] OPM_RD_TILE = 5'h07;
  localparam logic [1:0] OK_READY    = 2'b00;
  localparam logic [1:0] OK_OK       = 2'b01;
  localparam logic [1:0] OK_HOLD     = 2'b10;
  localparam logic [1:0] OK_FAULT    = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCommit,
    StDone,
    StFault
  } tileState_t;

  tileState_t   state, stateNext;
  logic [47:0]  reqAddr, reqAddrNext;
  logic [127:0] tile, tileNext;
  logic [1:0]   beat, beatNext;
  logic [7:0]   tout, toutNext;
  logic [1:0]   okNext;
  logic [127:0] dataNext;
  logic [47:0]  bkAddrNext;
  logic         bkReqNext;
  logic         startReq;

  logic         isRead;
  logic         sameAddr;
  logic [48:0]  tileEnd;
  logic         outOfRange;
  logic [7:0]   toutInc;

  assign isRead     = (memPcOpm == OPM_RD_TILE);
  assign sameAddr   = (memPcAddr == reqAddr);
  // One extra bit so a wrap past 2^48 also lands above the limit.
  assign tileEnd    = {1'b0, memPcAddr} + 49'd15;
  assign outOfRange = (tileEnd >= {1'b0, ADDR_LIMIT});
  assign toutInc    = tout + 8'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= StIdle;
      reqAddr   <= '0;
      tile      <= '0;
      beat      <= '0;
      tout      <= '0;
      memPcOK   <= OK_READY;
      memPcData <= '0;
      bkAddr    <= '0;
      bkReq     <= 1'b0;
    end else begin
      state     <= stateNext;
      reqAddr   <= reqAddrNext;
      tile      <= tileNext;
      beat      <= beatNext;
      tout      <= toutNext;
      memPcOK   <= okNext;
      memPcData <= dataNext;
      bkAddr    <= bkAddrNext;
      bkReq     <= bkReqNext;
    end
  end

  always_comb begin
    stateNext   = state;
    reqAddrNext = reqAddr;
    tileNext    = tile;
    beatNext    = beat;
    toutNext    = tout;
    okNext      = memPcOK;
    dataNext    = memPcData;
    bkAddrNext  = bkAddr;
    bkReqNext   = bkReq;
    startReq    = 1'b0;

    case (state)
      StIdle: startReq = isRead;

      StFetch: begin
        if (!isRead || !sameAddr) begin
          stateNext = StIdle;
          okNext    = OK_READY;
          bkReqNext = 1'b0;
        end else if (bkReq && bkOK) begin
          tileNext[{beat, 5'd0} +: 32] = bkData;
          toutNext = '0;
          if (beat == 2'd3) begin
            stateNext = StCommit;
            bkReqNext = 1'b0;
          end else begin
            beatNext   = beat + 2'd1;
            bkAddrNext = bkAddr + 48'd4;
          end
        end else if (toutInc == 8'(BEAT_TIMEOUT)) begin
          stateNext = StFault;
          okNext    = OK_FAULT;
          dataNext  = '0;
          bkReqNext = 1'b0;
          toutNext  = toutInc;
        end else begin
          toutNext = toutInc;
        end
      end

      // Publish the assembled tile one cycle after the last beat.
      StCommit: begin
        if (!isRead || !sameAddr) begin
          stateNext = StIdle;
          okNext    = OK_READY;
        end else begin
          stateNext = StDone;
          okNext    = OK_OK;
          dataNext  = tile;
        end
      end

      StDone, StFault: begin
        if (!isRead) begin
          stateNext = StIdle;
          okNext    = OK_READY;
        end else if (!sameAddr) begin
          startReq = 1'b1;
        end
      end

      default: begin
        stateNext = StIdle;
        okNext    = OK_READY;
        bkReqNext = 1'b0;
      end
    endcase

    if (startReq) begin
      reqAddrNext = memPcAddr;
      beatNext    = '0;
      toutNext    = '0;
      tileNext    = '0;
      if (outOfRange) begin
        stateNext = StFault;
        okNext    = OK_FAULT;
        dataNext  = '0;
        bkReqNext = 1'b0;
      end else begin
        stateNext  = StFetch;
        okNext     = OK_HOLD;
        bkReqNext  = 1'b1;
        bkAddrNext = {memPcAddr[47:2], 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_jx2_mem_tile_resp.sv
// Directed bench for jx2_mem_tile_resp: tile reads, stalls, faults, timeout,
// abort, back-to-back requests and reset mid-fetch.
module tb_jx2_mem_tile_resp;

  localparam logic [4:0] OPM_READY   = 5'h00;
  localparam logic [4:0] OPM_RD_TILE = 5'h07;
  localparam logic [1:0] OK_READY    = 2'b00;
  localparam logic [1:0] OK_OK       = 2'b01;
  localparam logic [1:0] OK_HOLD     = 2'b10;
  localparam logic [1:0] OK_FAULT    = 2'b11;

  logic         clock;
  logic         reset;
  logic [47:0]  memPcAddr;
  logic [4:0]   memPcOpm;
  logic [127:0] memPcData;
  logic [1:0]   memPcOK;
  logic [47:0]  bkAddr;
  logic         bkReq;
  logic [31:0]  bkData;
  logic         bkOK;

  int checks = 0;
  int errors = 0;

  jx2_mem_tile_resp dut (
    .clock     (clock),
    .reset     (reset),
    .memPcAddr (memPcAddr),
    .memPcOpm  (memPcOpm),
    .memPcData (memPcData),
    .memPcOK   (memPcOK),
    .bkAddr    (bkAddr),
    .bkReq     (bkReq),
    .bkData    (bkData),
    .bkOK      (bkOK)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; memPcOpm = OPM_READY; memPcAddr = '0; bkOK = 1'b0; bkData = '0;
    step(); step();
    checks++; if (memPcOK !== OK_READY) begin errors++; $display("FAIL reset_ok got %b exp %b", memPcOK, OK_READY); end
    checks++; if (memPcData !== 128'h0) begin errors++; $display("FAIL reset_data got %h exp 0", memPcData); end
    checks++; if (bkReq !== 1'b0) begin errors++; $display("FAIL reset_bkreq got %b exp 0", bkReq); end
    checks++; if (bkAddr !== 48'h0) begin errors++; $display("FAIL reset_bkaddr got %h exp 0", bkAddr); end
    reset = 1'b0;
    memPcOpm = 5'h03; memPcAddr = 48'h1000;
    step(); step();
    checks++; if (memPcOK !== OK_READY || bkReq !== 1'b0) begin errors++; $display("FAIL other_opm got ok=%b req=%b exp ok=00 req=0", memPcOK, bkReq); end
    memPcOpm = OPM_READY;
    step();
  endtask

  task automatic test_basic_read();
    logic [31:0] beats [4];
    logic [47:0] expAddr [4];
    beats   = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    expAddr = '{48'h1000, 48'h1004, 48'h1008, 48'h100C};
    memPcAddr = 48'h1000; memPcOpm = OPM_RD_TILE; bkOK = 1'b0;
    step();
    checks++; if (memPcOK !== OK_HOLD) begin errors++; $display("FAIL basic_hold got %b exp %b", memPcOK, OK_HOLD); end
    checks++; if (bkReq !== 1'b1) begin errors++; $display("FAIL basic_bkreq got %b exp 1", bkReq); end
    checks++; if (bkAddr !== expAddr[0]) begin errors++; $display("FAIL basic_addr0 got %h exp %h", bkAddr, expAddr[0]); end
    for (int i = 0; i < 4; i++) begin
      bkOK = 1'b1; bkData = beats[i];
      step();
      if (i < 3) begin
        checks++; if (bkAddr !== expAddr[i+1]) begin errors++; $display("FAIL basic_addr%0d got %h exp %h", i+1, bkAddr, expAddr[i+1]); end
        checks++; if (memPcOK !== OK_HOLD) begin errors++; $display("FAIL basic_hold_beat%0d got %b exp %b", i, memPcOK, OK_HOLD); end
      end
    end
    bkOK = 1'b0;
    checks++; if (memPcOK !== OK_HOLD || bkReq !== 1'b0) begin errors++; $display("FAIL basic_cycle5 got ok=%b req=%b exp ok=10 req=0", memPcOK, bkReq); end
    step();
    checks++; if (memPcOK !== OK_OK) begin errors++; $display("FAIL basic_ok_cycle6 got %b exp %b", memPcOK, OK_OK); end
    checks++; if (memPcData !== 128'h44444444_33333333_22222222_11111111) begin errors++; $display("FAIL basic_data got %h exp 44444444333333332222222211111111", memPcData); end
    step();
    checks++; if (memPcOK !== OK_OK) begin errors++; $display("FAIL basic_ok_held got %b exp %b", memPcOK, OK_OK); end
    memPcOpm = OPM_READY;
    step();
    checks++; if (memPcOK !== OK_READY) begin errors++; $display("FAIL basic_ready got %b exp %b", memPcOK, OK_READY); end
    checks++; if (memPcData !== 128'h44444444_33333333_22222222_11111111) begin errors++; $display("FAIL basic_data_retained got %h", memPcData); end
  endtask

  task automatic test_stalled();
    logic [31:0] beats [4];
    logic [47:0] expAddr [4];
    beats   = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003};
    expAddr = '{48'h2008, 48'h200C, 48'h2010, 48'h2014};
    memPcAddr = 48'h2008; memPcOpm = OPM_RD_TILE; bkOK = 1'b0;
    step();
    checks++; if (bkAddr !== expAddr[0]) begin errors++; $display("FAIL stall_addr0 got %h exp %h", bkAddr, expAddr[0]); end
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < 3; s++) begin
        step();
        checks++; if (bkAddr !== expAddr[b] || memPcOK !== OK_HOLD || bkReq !== 1'b1) begin
          errors++; $display("FAIL stall_b%0d_s%0d got addr=%h ok=%b req=%b exp addr=%h ok=10 req=1", b, s, bkAddr, memPcOK, bkReq, expAddr[b]);
        end
      end
      bkOK = 1'b1; bkData = beats[b];
      step();
      bkOK = 1'b0;
      if (b < 3) begin
        checks++; if (bkAddr !== expAddr[b+1]) begin errors++; $display("FAIL stall_next_addr%0d got %h exp %h", b+1, bkAddr, expAddr[b+1]); end
      end
    end
    checks++; if (memPcOK !== OK_HOLD) begin errors++; $display("FAIL stall_commit_hold got %b exp %b", memPcOK, OK_HOLD); end
    step();
    checks++; if (memPcOK !== OK_OK) begin errors++; $display("FAIL stall_ok got %b exp %b", memPcOK, OK_OK); end
    checks++; if (memPcData !== 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000) begin errors++; $display("FAIL stall_data got %h exp C0DE0003C0DE0002C0DE0001C0DE0000", memPcData); end
    memPcOpm = OPM_READY;
    step();
  endtask

  task automatic test_out_of_range();
    memPcAddr = 48'h0000_00FF_FFF8; memPcOpm = OPM_RD_TILE;
    step();
    checks++; if (memPcOK !== OK_FAULT) begin errors++; $display("FAIL oor_fault got %b exp %b", memPcOK, OK_FAULT); end
    checks++; if (memPcData !== 128'h0) begin errors++; $display("FAIL oor_data got %h exp 0", memPcData); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bkReq !== 1'b0 || memPcOK !== OK_FAULT) begin errors++; $display("FAIL oor_hold%0d got req=%b ok=%b exp req=0 ok=11", i, bkReq, memPcOK); end
    end
    memPcOpm = OPM_READY;
    step();
    checks++; if (memPcOK !== OK_READY) begin errors++; $display("FAIL oor_ready got %b exp %b", memPcOK, OK_READY); end
    memPcAddr = 48'hFFFF_FFFF_FFF8; memPcOpm = OPM_RD_TILE;
    step();
    checks++; if (memPcOK !== OK_FAULT || bkReq !== 1'b0) begin errors++; $display("FAIL wrap_fault got ok=%b req=%b exp ok=11 req=0", memPcOK, bkReq); end
    memPcOpm = OPM_READY;
    step();
    memPcAddr = 48'h0000_00FF_FFF0; memPcOpm = OPM_RD_TILE;
    step();
    checks++; if (memPcOK !== OK_HOLD || bkReq !== 1'b1) begin errors++; $display("FAIL limit_edge got ok=%b req=%b exp ok=10 req=1", memPcOK, bkReq); end
    memPcOpm = OPM_READY;
    step();
    checks++; if (memPcOK !== OK_READY || bkReq !== 1'b0) begin errors++; $display("FAIL limit_abort got ok=%b req=%b exp ok=00 req=0", memPcOK, bkReq); end
  endtask

  task automatic test_timeout();
    int high;
    memPcAddr = 48'h3000; memPcOpm = OPM_RD_TILE; bkOK = 1'b0;
    step();
    high = (bkReq === 1'b1 && memPcOK === OK_HOLD) ? 1 : 0;
    for (int i = 0; i < 254; i++) begin
      step();
      if (bkReq === 1'b1 && memPcOK === OK_HOLD) high++;
    end
    checks++; if (high != 255) begin errors++; $display("FAIL timeout_req_cycles got %0d exp 255", high); end
    step();
    checks++; if (memPcOK !== OK_FAULT || bkReq !== 1'b0) begin errors++; $display("FAIL timeout_fault got ok=%b req=%b exp ok=11 req=0", memPcOK, bkReq); end
    checks++; if (memPcData !== 128'h0) begin errors++; $display("FAIL timeout_data got %h exp 0", memPcData); end
    memPcOpm = OPM_READY;
    step();
    checks++; if (memPcOK !== OK_READY) begin errors++; $display("FAIL timeout_ready got %b exp %b", memPcOK, OK_READY); end
  endtask

  task automatic test_abort();
    logic [31:0] beats [4];
    logic [47:0] expAddr [4];
    beats   = '{32'h5A5A0000, 32'h5A5A0001, 32'h5A5A0002, 32'h5A5A0003};
    expAddr = '{48'h4000, 48'h4004, 48'h4008, 48'h400C};
    memPcAddr = 48'h4000; memPcOpm = OPM_RD_TILE; bkOK = 1'b0;
    step();
    bkOK = 1'b1; bkData = 32'hAAAA0000; step();
    bkData = 32'hAAAA0001; step();
    memPcOpm = OPM_READY; bkData = 32'hDEADBEEF;
    step();
    bkOK = 1'b0;
    checks++; if (memPcOK !== OK_READY || bkReq !== 1'b0) begin errors++; $display("FAIL abort_idle got ok=%b req=%b exp ok=00 req=0", memPcOK, bkReq); end
    memPcOpm = OPM_RD_TILE;
    step();
    checks++; if (memPcOK !== OK_HOLD || bkAddr !== expAddr[0]) begin errors++; $display("FAIL abort_restart got ok=%b addr=%h exp ok=10 addr=%h", memPcOK, bkAddr, expAddr[0]); end
    for (int i = 0; i < 4; i++) begin
      bkOK = 1'b1; bkData = beats[i];
      step();
      if (i < 3) begin
        checks++; if (bkAddr !== expAddr[i+1]) begin errors++; $display("FAIL abort_addr%0d got %h exp %h", i+1, bkAddr, expAddr[i+1]); end
      end
    end
    bkOK = 1'b0;
    step();
    checks++; if (memPcOK !== OK_OK) begin errors++; $display("FAIL abort_ok got %b exp %b", memPcOK, OK_OK); end
    checks++; if (memPcData !== 128'h5A5A0003_5A5A0002_5A5A0001_5A5A0000) begin errors++; $display("FAIL abort_data got %h exp 5A5A00035A5A00025A5A00015A5A0000", memPcData); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] beats [4];
    beats = '{32'h6B6B0000, 32'h6B6B0001, 32'h6B6B0002, 32'h6B6B0003};
    step();
    checks++; if (memPcOK !== OK_OK) begin errors++; $display("FAIL b2b_same_addr got %b exp %b", memPcOK, OK_OK); end
    memPcAddr = 48'h5000;
    step();
    checks++; if (memPcOK !== OK_HOLD || bkReq !== 1'b1 || bkAddr !== 48'h5000) begin
      errors++; $display("FAIL b2b_new_req got ok=%b req=%b addr=%h exp ok=10 req=1 addr=5000", memPcOK, bkReq, bkAddr);
    end
    for (int i = 0; i < 4; i++) begin
      bkOK = 1'b1; bkData = beats[i];
      step();
    end
    bkOK = 1'b0;
    step();
    checks++; if (memPcOK !== OK_OK) begin errors++; $display("FAIL b2b_ok got %b exp %b", memPcOK, OK_OK); end
    checks++; if (memPcData !== 128'h6B6B0003_6B6B0002_6B6B0001_6B6B0000) begin errors++; $display("FAIL b2b_data got %h exp 6B6B00036B6B00026B6B00016B6B0000", memPcData); end
    memPcOpm = OPM_READY;
    step();
  endtask

  task automatic test_reset_mid_fetch();
    memPcAddr = 48'h6000; memPcOpm = OPM_RD_TILE; bkOK = 1'b0;
    step();
    bkOK = 1'b1; bkData = 32'h77777777;
    step();
    bkOK = 1'b0; reset = 1'b1;
    step();
    checks++; if (memPcOK !== OK_READY || bkReq !== 1'b0) begin errors++; $display("FAIL rst_mid got ok=%b req=%b exp ok=00 req=0", memPcOK, bkReq); end
    checks++; if (memPcData !== 128'h0) begin errors++; $display("FAIL rst_mid_data got %h exp 0", memPcData); end
    reset = 1'b0; memPcOpm = OPM_READY;
    step();
    checks++; if (memPcOK !== OK_READY || bkReq !== 1'b0) begin errors++; $display("FAIL rst_after got ok=%b req=%b exp ok=00 req=0", memPcOK, bkReq); end
  endtask

  initial begin
    reset = 1'b1; memPcOpm = OPM_READY; memPcAddr = '0; bkOK = 1'b0; bkData = '0;
    test_reset();
    test_basic_read();
    test_stalled();
    test_out_of_range();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
